// File: rtl/cvsd_pkg.sv
// Shared definitions for the CVSD packer slice.
//   CVSD_WORD_W_DEF     default packed word width
//   CVSD_FIFO_DEPTH_DEF default output FIFO depth (words)
//   ovf_cnt_t           dropped-word counter type
package cvsd_pkg;
  localparam int CVSD_WORD_W_DEF     = 8;
  localparam int CVSD_FIFO_DEPTH_DEF = 4;

  typedef logic [7:0] ovf_cnt_t;

  localparam ovf_cnt_t OVF_CNT_MAX = 8'hFF;
endpackage

// File: rtl/cvsd_fifo.sv
// Synchronous FIFO for completed CVSD words.
// Ports:
//   clk, rst        clock, async active-high reset
//   push, push_data write request; accepted when not full, or when full with a
//                   pop in the same cycle
//   pop             read request; ignored when empty
//   rd_data         head entry (registered storage, indexed by read pointer)
//   full, empty     status
//   level           occupancy 0..DEPTH
module cvsd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  // one extra pointer bit distinguishes full from empty
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  // a full FIFO still takes a word when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      // storage is cleared so the head reads as zero out of reset
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/cvsd_packer.sv
// CVSD bit packer: assembles the 1-bit CVSD stream into WORD_W-bit words and
// queues them in a DEPTH-word FIFO for a valid/ready consumer.
// Optional feature macro: CVSD_PACKER_OVF_CNT_EN (saturating dropped-word
// counter on ovf_cnt_o; tied to 0 when undefined).
// Ports:
//   clk_i, rst_i  clock, async active-high reset
//   enable_i      sample strobe, data_i taken when high
//   data_i        CVSD bit
//   flush_i       close out a partial word, zero-padded
//   data_o        FIFO head word
//   valid_o       FIFO non-empty
//   ready_i       consumer accept
//   level_o       FIFO occupancy
//   overflow_o    sticky: a completed word was dropped
//   ovf_cnt_o     dropped-word count
module cvsd_packer
  import cvsd_pkg::*;
#(
  parameter int WORD_W    = CVSD_WORD_W_DEF,
  parameter int DEPTH     = CVSD_FIFO_DEPTH_DEF,
  parameter bit MSB_FIRST = 1'b1,
  localparam int LW       = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              data_i,
  input  logic              flush_i,
  output logic [WORD_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [LW-1:0]     level_o,
  output logic              overflow_o,
  output logic [7:0]        ovf_cnt_o
);

  localparam int            BW  = $clog2(WORD_W);
  localparam logic [BW:0]   W_L = (BW+1)'(WORD_W);
  localparam logic [BW-1:0] LAST = BW'(WORD_W - 1);

  logic [WORD_W-1:0] sreg, sreg_nxt, push_word;
  logic [BW-1:0]     bcnt, bcnt_nxt;
  logic [BW:0]       shamt;
  logic              push, pop, full, empty, drop;

  // Assembler. bcnt_nxt already accounts for a same-cycle strobe, so it is
  // exactly the number of bits a flush has to emit (0 after a word wraps).
  always_comb begin
    sreg_nxt  = sreg;
    bcnt_nxt  = bcnt;
    push      = 1'b0;
    push_word = sreg;
    shamt     = W_L - {1'b0, bcnt};
    if (enable_i) begin
      if (MSB_FIRST) sreg_nxt = {sreg[WORD_W-2:0], data_i};
      else           sreg_nxt = {data_i, sreg[WORD_W-1:1]};
      bcnt_nxt = (bcnt == LAST) ? '0 : bcnt + 1'b1;
    end
    shamt = W_L - {1'b0, bcnt_nxt};
    if (enable_i && bcnt == LAST) begin
      // full word wins over a same-cycle flush; nothing is left to pad
      push      = 1'b1;
      push_word = sreg_nxt;
    end else if (flush_i && bcnt_nxt != '0) begin
      // left/right align the k held bits and zero-fill the rest
      push      = 1'b1;
      push_word = MSB_FIRST ? (sreg_nxt << shamt) : (sreg_nxt >> shamt);
      bcnt_nxt  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sreg <= '0;
      bcnt <= '0;
    end else begin
      sreg <= sreg_nxt;
      bcnt <= bcnt_nxt;
    end
  end

  assign pop     = valid_o & ready_i;
  assign valid_o = ~empty;
  assign drop    = push & full & ~pop;

  cvsd_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .rd_data   (data_o),
    .full      (full),
    .empty     (empty),
    .level     (level_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     overflow_o <= 1'b0;
    else if (drop) overflow_o <= 1'b1;
  end

`ifdef CVSD_PACKER_OVF_CNT_EN
  ovf_cnt_t ovf_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                            ovf_cnt <= '0;
    else if (drop && ovf_cnt != OVF_CNT_MAX) ovf_cnt <= ovf_cnt + 1'b1;
  end

  assign ovf_cnt_o = ovf_cnt;
`else
  assign ovf_cnt_o = '0;
`endif

endmodule
